// File: rtl/demux_sipo_1to8.sv
// Serial-to-parallel 1:WIDTH demultiplexer: steers accepted serial bits into
// successive word positions (first bit -> dout[0]) and hands out whole words.
module demux_sipo_1to8 #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] sel
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic [WIDTH-1:0] dout_n;
    logic             dout_valid_n;
    logic             in_acc;
    logic             out_acc;

    // Readiness is the only combinational output: a held word blocks input
    // unless the consumer takes it this same cycle.
    assign din_ready = !rst && (state == FILL || dout_ready);
    assign in_acc    = din_valid && din_ready;
    assign out_acc   = dout_valid && dout_ready;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            sel        <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            shadow     <= shadow_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n      = state;
        sel_n        = sel;
        shadow_n     = shadow;
        dout_n       = dout;
        dout_valid_n = dout_valid;

        unique case (state)
            FILL: begin
                if (clr) begin
                    sel_n    = '0;
                    shadow_n = '0;
                end else if (in_acc) begin
                    shadow_n[sel] = din;
                    if (sel == SEL_LAST) begin
                        dout_n       = {din, shadow[WIDTH-2:0]};
                        dout_valid_n = 1'b1;
                        sel_n        = '0;
                        state_n      = FULL;
                    end else begin
                        sel_n = sel + SEL_W'(1);
                    end
                end
            end
            FULL: begin
                if (out_acc) begin
                    dout_valid_n = 1'b0;
                    state_n      = FILL;
                end
                // An input accept here implies the word leaves this cycle,
                // so the new bit opens the next word at position 0.
                if (clr) begin
                    sel_n    = '0;
                    shadow_n = '0;
                end else if (in_acc) begin
                    shadow_n[0] = din;
                    sel_n       = SEL_W'(1);
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_sipo_1to8.sv
// Scoreboard bench for demux_sipo_1to8: the driver queues each expected word,
// a negedge monitor pops and compares on every output handshake.
module tb_demux_sipo_1to8;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] sel;

    int         n_tests;
    int         n_fail;
    int         n_pushed;
    int         n_popped;
    logic [7:0] exp_q[$];
    logic       hold;
    logic [7:0] held;
    bit         rnd_mode;

    demux_sipo_1to8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sel        (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Output monitor: handshake pops and stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold && dout_valid)
                check("hold_stable", 32'(dout), 32'(held));
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word at %0t: got %0h, expected none", $time, dout);
                end else begin
                    n_popped++;
                    check("word", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
            hold = dout_valid && !dout_ready;
            held = dout;
        end
    end

    // Present one bit, wait (bounded) for readiness, let it be accepted
    task automatic send_bit(input logic b, input int exp_sel, input bit strict);
        bit got;
        int waited;
        got    = 1'b0;
        waited = 0;
        din       = b;
        din_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (din_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(posedge clk);
            #1;
            if (rnd_mode) dout_ready = 1'($urandom_range(0, 1));
        end
        if (!got) begin
            check("din_ready_timeout", 32'(din_ready), 32'd1);
        end else begin
            check("sel", 32'(sel), 32'(exp_sel));
            if (strict) check("no_bubble", 32'(waited), 32'd0);
        end
        @(posedge clk);
        #1;
        if (rnd_mode) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [7:0] w, input int first, input bit push, input bit strict);
        if (push) begin
            exp_q.push_back(w);
            n_pushed++;
        end
        for (int i = first; i < 8; i++) begin
            if (rnd_mode && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                @(posedge clk);
                #1;
                dout_ready = 1'($urandom_range(0, 1));
            end
            send_bit(w[i], i, strict);
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_pushed = 0; n_popped = 0;
        hold = 1'b0; held = '0; rnd_mode = 1'b0;
        rst = 1'b1; clr = 1'b0; din = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;

        // Basic word 1,0,1,1,0,0,1,0 -> 8'h4D
        send_word(8'h4D, 0, 1'b1, 1'b1);
        din_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_hi", 32'(dout_valid), 32'd1);
        check("t1_dout", 32'(dout), 32'h4D);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_valid_lo", 32'(dout_valid), 32'd0);
        check("t1_sel_end", 32'(sel), 32'd0);
        idle(2);

        // Back-to-back words, no bubbles
        send_word(8'hA5, 0, 1'b1, 1'b1);
        send_word(8'h3C, 0, 1'b1, 1'b1);
        idle(3);

        // Backpressure on a completed 8'hFF, overlapped bit then completes 8'h5A
        dout_ready = 1'b0;
        send_word(8'hFF, 0, 1'b1, 1'b0);
        din = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_din_ready", 32'(din_ready), 32'd0);
            check("bp_dout", 32'(dout), 32'hFF);
            check("bp_valid", 32'(dout_valid), 32'd1);
            check("bp_sel", 32'(sel), 32'd0);
            @(posedge clk); #1;
        end
        exp_q.push_back(8'h5A);
        n_pushed++;
        dout_ready = 1'b1;
        send_bit(1'b0, 0, 1'b1);
        check("bp_sel_after", 32'(sel), 32'd1);
        check("bp_valid_after", 32'(dout_valid), 32'd0);
        send_word(8'h5A, 1, 1'b0, 1'b1);
        idle(3);

        // Flush after 1,1,1 (bit presented during clr is discarded)
        send_bit(1'b1, 0, 1'b1);
        send_bit(1'b1, 1, 1'b1);
        send_bit(1'b1, 2, 1'b1);
        din = 1'b1;
        din_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        check("clr_din_ready", 32'(din_ready), 32'd1);
        @(posedge clk); #1;
        clr = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("clr_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        send_word(8'h01, 0, 1'b1, 1'b1);
        idle(3);

        // Reset mid-word
        for (int i = 0; i < 5; i++) send_bit(1'b1, i, 1'b1);
        rst = 1'b1;
        din_valid = 1'b1;
        @(negedge clk);
        check("rstw_din_ready", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("rstw_dout", 32'(dout), 32'h00);
        check("rstw_valid", 32'(dout_valid), 32'd0);
        check("rstw_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        send_word(8'hC3, 0, 1'b1, 1'b1);
        idle(3);

        // Reset while holding a full word
        dout_ready = 1'b0;
        send_word(8'h77, 0, 1'b0, 1'b0);
        din_valid = 1'b0;
        @(negedge clk);
        check("rstf_held", 32'(dout), 32'h77);
        check("rstf_held_valid", 32'(dout_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        dout_ready = 1'b1;
        din_valid = 1'b1;
        @(negedge clk);
        check("rstf_din_ready", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("rstf_dout", 32'(dout), 32'h00);
        check("rstf_valid", 32'(dout_valid), 32'd0);
        check("rstf_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        send_word(8'h96, 0, 1'b1, 1'b1);
        idle(3);

        // Random valid/ready gaps over 200 words
        rnd_mode = 1'b1;
        for (int w = 0; w < 200; w++) send_word(8'($urandom_range(0, 255)), 0, 1'b1, 1'b0);
        rnd_mode = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("word_count", 32'(n_popped), 32'(n_pushed));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_sipo_1to8.md
# demux_sipo_1to8

Sequential 1:8 demultiplexer that steers a serial bit stream into successive bit positions of an internal word and presents the assembled word on a parallel port with valid/ready handshakes. It is the receive-side counterpart of the 8:1 bit-select multiplexer: position k of the output word holds the k-th accepted serial bit, so the first bit lands in dout[0]. It sits between a serial bit producer and a byte-wide consumer.

## Interface
- WIDTH, 8, output word width and number of demux positions; must be ≥ 2. The position counter is $clog2(WIDTH) bits wide.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous flush; discards a partially filled word.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept din this cycle.
- dout  output  WIDTH  assembled parallel word.
- dout_valid  output  1  dout holds a complete word.
- dout_ready  input  1  consumer accepts dout this cycle.
- sel  output  $clog2(WIDTH)  demux position the next accepted bit will be written to.

## Operation
- Reset (rst high at a clock edge):
  - state ← FILL, sel ← 0, shadow ← 0, dout ← 0, dout_valid ← 0.
  - While rst is high, din_ready = 0 and all other inputs are ignored.
- Input accept: a bit is accepted when din_valid && din_ready.
- Output accept: a word is accepted when dout_valid && dout_ready.
- Input readiness: din_ready = !rst && (state == FILL || dout_ready).
- State FILL (dout_valid = 0):
  - On each accept: shadow[sel] ← din and sel ← sel + 1.
  - If the accepted bit's sel was WIDTH−1: dout ← {din, shadow[WIDTH−2:0]}, dout_valid ← 1, sel ← 0, state ← FULL.
- State FULL (dout_valid = 1):
  - dout and dout_valid are held stable until the output is accepted.
  - Output accepted, no input accept: dout_valid ← 0, state ← FILL.
  - Output accepted and input accepted in the same cycle: dout_valid ← 0, shadow[0] ← din, sel ← 1, state ← FILL.
  - Exception for WIDTH = 2 is not special-cased; the same rule applies.
- clr (evaluated when rst is low; takes priority over input accept):
  - sel ← 0 and shadow ← 0.
  - In FULL, the held dout/dout_valid is not affected.
  - din_ready still follows its formula, but a bit accepted in a clr cycle is discarded.
- sel never exceeds WIDTH−1. It wraps from WIDTH−1 to 0 only on completion of a word.
- Bits within shadow that are not yet written are don't-care to the consumer. dout only ever carries complete words.

## Timing
- Latency: dout_valid rises on the clock edge that accepts the WIDTH-th bit. dout is valid in the cycle immediately after that bit's accept cycle.
- Throughput: one word per WIDTH cycles with din_valid and dout_ready held high. There are no bubbles, because the overlap accept in FULL writes position 0.
- Backpressure: with dout_ready low in FULL, din_ready = 0. No bit is lost or overwritten, and dout is stable.
- Reset mid-word: the partial word is lost, and the next accepted bit is written to position 0.
- Reset mid-FULL: dout_valid drops in the cycle after the reset edge, and dout reads 0.
- All outputs except din_ready are registered. din_ready is combinational from state, rst and dout_ready.

## Test plan
- Reset, then feed bits 1,0,1,1,0,0,1,0 (first to last) with dout_ready = 1:
  - sel steps 0..7.
  - dout_valid = 1 for exactly one cycle with dout = 8'h4D.
  - sel = 0 afterwards.
- Back-to-back words with din_valid and dout_ready held high, streaming 8'hA5 then 8'h3C LSB-first:
  - dout_valid pulses every 8 cycles with dout = 8'hA5, then 8'h3C.
  - din_ready stays 1 throughout.
- Backpressure: complete 8'hFF with dout_ready = 0 for 5 cycles while din_valid = 1:
  - din_ready = 0 and dout = 8'hFF stays stable.
  - On dout_ready = 1, the overlapped bit is written to position 0 and sel = 1 on the next cycle.
- clr after 3 bits (1,1,1), then feed 8'h01 LSB-first:
  - Output is 8'h01, with no residue from the flushed bits.
- rst asserted after 5 bits, and separately while in FULL:
  - dout = 0, dout_valid = 0 and sel = 0 the next cycle.
  - din_ready = 0 during rst.
  - The next word assembles correctly from position 0.
- Randomised din_valid and dout_ready gaps over 200 words against a scoreboard:
  - Every word matches the serial bits in LSB-first order.
  - No word is dropped or duplicated.
  - dout never changes while dout_valid && !dout_ready.
